// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver: FIFO geometry, entry layout, outcome classification.
// Statistics counters are built only when BRANCH_STATS_EN is defined (off by default).
package branch_resolver_pkg;

  localparam int BRANCH_FIFO_DEPTH  = 16;
  localparam int BRANCH_FIFO_ADDR_W = 4;
  localparam int PC_W               = 32;
  localparam int STAT_W             = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred_jump;
    logic [PC_W-1:0] pred_target;
  } br_entry_t;

  typedef enum logic [1:0] {
    RES_CORRECT  = 2'd0,
    RES_DIR_MISS = 2'd1,
    RES_TGT_MISS = 2'd2
  } resolve_e;

  // A taken/taken pair still mispredicts when the fetched target was wrong.
  function automatic resolve_e classify(input br_entry_t       e,
                                        input logic            taken,
                                        input logic [PC_W-1:0] target);
    if (taken != e.pred_jump) return RES_DIR_MISS;
    if (taken && (target != e.pred_target)) return RES_TGT_MISS;
    return RES_CORRECT;
  endfunction

  function automatic logic [PC_W-1:0] fallthrough_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/commit/update bundle of the branch resolver; slave = resolver side, master = environment side.
// Stat outputs exist only when BRANCH_STATS_EN is defined.
interface branch_resolver_if;
  import branch_resolver_pkg::*;

  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic            if_pred_jump;
  logic [PC_W-1:0] if_pred_target;
  logic            full;

  logic            commit_valid;
  logic            commit_taken;
  logic [PC_W-1:0] commit_target;

  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_jump;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic            err_underflow;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  modport slave (
    input  if_valid, if_pc, if_pred_jump, if_pred_target,
    input  commit_valid, commit_taken, commit_target,
    output full, upd_valid, upd_pc, upd_jump, mispredict, redirect_pc, err_underflow,
    output stat_branches, stat_mispredicts
  );

  modport master (
    output if_valid, if_pc, if_pred_jump, if_pred_target,
    output commit_valid, commit_taken, commit_target,
    input  full, upd_valid, upd_pc, upd_jump, mispredict, redirect_pc, err_underflow,
    input  stat_branches, stat_mispredicts
  );
`else
  modport slave (
    input  if_valid, if_pc, if_pred_jump, if_pred_target,
    input  commit_valid, commit_taken, commit_target,
    output full, upd_valid, upd_pc, upd_jump, mispredict, redirect_pc, err_underflow
  );

  modport master (
    output if_valid, if_pc, if_pred_jump, if_pred_target,
    output commit_valid, commit_taken, commit_target,
    input  full, upd_valid, upd_pc, upd_jump, mispredict, redirect_pc, err_underflow
  );
`endif

endinterface

// File: rtl/branch_fifo.sv
// In-order FIFO of outstanding branches: synchronous push/pop/flush, async-reset pointers,
// head entry readable in the same cycle it is popped.
module branch_fifo
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH  = BRANCH_FIFO_DEPTH,
  parameter int ADDR_W = BRANCH_FIFO_ADDR_W
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      en_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      flush_i,
  input  br_entry_t push_entry_i,
  output br_entry_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  br_entry_t         mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot this cycle, so a full FIFO may still accept a concurrent push.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (en_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i && do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves committed conditional branches against their recorded prediction, drives predictor
// updates and a registered redirect/flush. Optional counters: BRANCH_STATS_EN.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH  = BRANCH_FIFO_DEPTH,
  parameter int ADDR_W = BRANCH_FIFO_ADDR_W
) (
  input logic               clk_in,
  input logic               rst_in,
  input logic               rdy_in,
  branch_resolver_if.slave  bus
);

  br_entry_t       head;
  br_entry_t       push_entry;
  logic            fifo_empty;
  logic            fifo_full;
  logic            flush;
  logic            commit_ok;
  resolve_e        outcome;

  logic            upd_valid_q, upd_valid_d;
  logic [PC_W-1:0] upd_pc_q, upd_pc_d;
  logic            upd_jump_q, upd_jump_d;
  logic            mispredict_q, mispredict_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            err_underflow_q, err_underflow_d;

  // The redirect cycle is also the flush cycle: anything fetched or committed then is wrong-path.
  assign flush      = mispredict_q;
  assign commit_ok  = bus.commit_valid && !fifo_empty && !flush;
  assign push_entry = '{pc: bus.if_pc, pred_jump: bus.if_pred_jump, pred_target: bus.if_pred_target};
  assign outcome    = classify(head, bus.commit_taken, bus.commit_target);

  branch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i        (clk_in),
    .rst_i        (rst_in),
    .en_i         (rdy_in),
    .push_i       (bus.if_valid),
    .pop_i        (commit_ok),
    .flush_i      (flush),
    .push_entry_i (push_entry),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  always_comb begin
    upd_valid_d     = commit_ok;
    upd_pc_d        = upd_pc_q;
    upd_jump_d      = upd_jump_q;
    mispredict_d    = 1'b0;
    redirect_pc_d   = redirect_pc_q;
    err_underflow_d = err_underflow_q;
    if (commit_ok) begin
      upd_pc_d      = head.pc;
      upd_jump_d    = bus.commit_taken;
      mispredict_d  = (outcome != RES_CORRECT);
      redirect_pc_d = bus.commit_taken ? bus.commit_target : fallthrough_pc(head.pc);
    end else if (bus.commit_valid) begin
      err_underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      upd_valid_q     <= 1'b0;
      upd_pc_q        <= '0;
      upd_jump_q      <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
      err_underflow_q <= 1'b0;
    end else if (rdy_in) begin
      upd_valid_q     <= upd_valid_d;
      upd_pc_q        <= upd_pc_d;
      upd_jump_q      <= upd_jump_d;
      mispredict_q    <= mispredict_d;
      redirect_pc_q   <= redirect_pc_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign bus.full          = fifo_full;
  assign bus.upd_valid     = upd_valid_q;
  assign bus.upd_pc        = upd_pc_q;
  assign bus.upd_jump      = upd_jump_q;
  assign bus.mispredict    = mispredict_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign bus.err_underflow = err_underflow_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches_q;
  logic [STAT_W-1:0] stat_mispredicts_q;

  // Counters advance on the same edge that registers the update/redirect and saturate at all-ones.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (rdy_in) begin
      if (upd_valid_d && (stat_branches_q != '1))
        stat_branches_q <= stat_branches_q + STAT_W'(1);
      if (mispredict_d && (stat_mispredicts_q != '1))
        stat_mispredicts_q <= stat_mispredicts_q + STAT_W'(1);
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
`else
  // Default build carries no statistics state.
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a spec-level FIFO model predicts each update/redirect,
// which is queued at commit time and compared when the registered update appears.
module tb_branch_resolver;

  typedef struct {
    logic [31:0] pc;
    logic        pj;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic        jump;
    logic        mis;
    logic [31:0] redir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  int checks = 0;
  int errors = 0;

  ent_t model_q[$];
  exp_t exp_q[$];
  bit   flush_pending = 1'b0;
  logic exp_err = 1'b0;

  branch_resolver_if bus();

  branch_resolver #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance the model for the inputs currently driven, clock once, then compare.
  task automatic step();
    int   pre_size;
    bit   popped;
    bit   mis_next;
    ent_t e;
    exp_t x;
    pre_size = model_q.size();
    popped   = 1'b0;
    mis_next = 1'b0;
    if (rdy) begin
      if (bus.commit_valid) begin
        if (flush_pending || pre_size == 0) begin
          exp_err = 1'b1;
        end else begin
          e       = model_q.pop_front();
          popped  = 1'b1;
          x.pc    = e.pc;
          x.jump  = bus.commit_taken;
          x.mis   = (bus.commit_taken != e.pj) || (bus.commit_taken && (bus.commit_target != e.tgt));
          x.redir = bus.commit_taken ? bus.commit_target : e.pc + 32'd4;
          exp_q.push_back(x);
          mis_next = x.mis;
        end
      end
      if (bus.if_valid && !flush_pending && (pre_size < 16 || popped)) begin
        e.pc  = bus.if_pc;
        e.pj  = bus.if_pred_jump;
        e.tgt = bus.if_pred_target;
        model_q.push_back(e);
      end
      if (flush_pending) model_q.delete();
      flush_pending = mis_next;
    end
    @(posedge clk);
    #1;
    if (rdy) begin
      if (bus.upd_valid) begin
        $display("upd pc=%08h jump=%0d mispredict=%0d redirect=%08h",
                 bus.upd_pc, bus.upd_jump, bus.mispredict, bus.redirect_pc);
        if (exp_q.size() == 0) begin
          check("unexpected_upd", bus.upd_valid, 0);
        end else begin
          x = exp_q.pop_front();
          check("upd_pc", bus.upd_pc, x.pc);
          check("upd_jump", bus.upd_jump, x.jump);
          check("mispredict", bus.mispredict, x.mis);
          if (x.mis) check("redirect_pc", bus.redirect_pc, x.redir);
        end
      end else begin
        if (exp_q.size() != 0) begin
          x = exp_q.pop_front();
          check("missing_upd", bus.upd_valid, 1);
        end
        check("idle_mispredict", bus.mispredict, 0);
      end
    end
    check("err_underflow", bus.err_underflow, exp_err);
    check("full", bus.full, model_q.size() == 16);
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic pj, input logic [31:0] tgt,
                       input logic cv, input logic ct, input logic [31:0] ctgt);
    bus.if_valid       = iv;
    bus.if_pc          = pc;
    bus.if_pred_jump   = pj;
    bus.if_pred_target = tgt;
    bus.commit_valid   = cv;
    bus.commit_taken   = ct;
    bus.commit_target  = ctgt;
    step();
  endtask

  task automatic push(input logic [31:0] pc, input logic pj, input logic [31:0] tgt);
    drive(1'b1, pc, pj, tgt, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic commit(input logic taken, input logic [31:0] tgt);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, taken, tgt);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_valid       = 1'b0;
    bus.if_pc          = '0;
    bus.if_pred_jump   = 1'b0;
    bus.if_pred_target = '0;
    bus.commit_valid   = 1'b0;
    bus.commit_taken   = 1'b0;
    bus.commit_target  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_upd_valid", bus.upd_valid, 0);
    check("rst_upd_pc", bus.upd_pc, 0);
    check("rst_upd_jump", bus.upd_jump, 0);
    check("rst_mispredict", bus.mispredict, 0);
    check("rst_redirect_pc", bus.redirect_pc, 0);
    check("rst_err", bus.err_underflow, 0);
    check("rst_full", bus.full, 0);
    rst = 1'b0;
    idle();

    // Correct not-taken prediction
    push(32'h100, 1'b0, 32'h0);
    commit(1'b0, 32'h0);
    idle();

    // Direction mispredict flushes the younger 0x204 entry
    push(32'h200, 1'b1, 32'h280);
    push(32'h204, 1'b0, 32'h0);
    commit(1'b0, 32'h0);
    idle();
    push(32'h700, 1'b0, 32'h0);
    commit(1'b0, 32'h0);
    idle();

    // Target mispredict
    push(32'h300, 1'b1, 32'h400);
    commit(1'b1, 32'h500);
    idle();
    idle();

    // Fill, ignored 17th push, alternating traffic across the pointer wrap, drain
    for (int i = 0; i < 16; i++) push(32'(i * 4), 1'b0, 32'h0);
    check("full_after_16", bus.full, 1);
    push(32'h40, 1'b0, 32'h0);
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) commit(1'b0, 32'h0);
      else push(32'h1000 + 32'(k * 4), 1'b0, 32'h0);
    end
    for (int n = 0; n < 16 && model_q.size() > 0; n++) commit(1'b0, 32'h0);
    idle();

    // Fetch in the flush cycle is dropped; the next commit underflows
    push(32'h800, 1'b0, 32'h0);
    commit(1'b1, 32'h900);
    drive(1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    commit(1'b0, 32'h0);
    check("err_after_collision", bus.err_underflow, 1);
    idle();

    // Global enable low holds the pending update and ignores the commit
    push(32'hA00, 1'b0, 32'h0);
    push(32'hA04, 1'b0, 32'h0);
    commit(1'b0, 32'h0);
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      commit(1'b0, 32'h0);
      check("frozen_upd_valid", bus.upd_valid, 1);
      check("frozen_upd_pc", bus.upd_pc, 32'hA00);
    end
    rdy = 1'b1;
    commit(1'b0, 32'h0);
    idle();

    // Asynchronous reset mid-stream, with an entry still queued
    push(32'hB00, 1'b0, 32'h0);
    push(32'hB04, 1'b0, 32'h0);
    commit(1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("async_upd_valid", bus.upd_valid, 0);
    check("async_upd_pc", bus.upd_pc, 0);
    check("async_redirect_pc", bus.redirect_pc, 0);
    check("async_err", bus.err_underflow, 0);
    model_q.delete();
    exp_q.delete();
    flush_pending = 1'b0;
    exp_err = 1'b0;
    bus.if_valid     = 1'b0;
    bus.commit_valid = 1'b0;
    #9;
    rst = 1'b0;
    commit(1'b0, 32'h0);
    idle();
    check("drained_scoreboard", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
